usb_tx: RTL
===========

// Module: usb_tx
// PURPOSE
// - USB full-speed packet transmitter; transmit-side counterpart of usb_rx in the USB-AHB module.
// - Takes a packet command from the protocol controller and pulls payload bytes from the shared data buffer.
// - Serializes SYNC, PID, payload, CRC16 and EOP, with bit stuffing and NRZI encoding, onto dplus_out/dminus_out.
// PARAMETERS
// - CLKS_PER_BIT  8  clk cycles per USB bit time (96 MHz / 12 Mbps); legal range >= 2
// PORTS
// - clk                in   1  system clock; all logic on its rising edge
// - n_rst              in   1  reset: synchronous, active-low
// - tx_packet          in   3  command: 0 none, 1 DATA0, 2 ACK, 3 NAK, 4 STALL, 5-7 illegal
// - buffer_occupancy   in   7  bytes waiting in data buffer (0..64)
// - tx_packet_data     in   8  buffer head byte; valid in the cycle get_tx_packet_data=1
// - get_tx_packet_data out  1  one-cycle pop strobe to data buffer
// - tx_transfer_active out  1  high while a packet is being sent
// - tx_error           out  1  one-cycle pulse: illegal command rejected
// - dplus_out          out  1  D+ line
// - dminus_out         out  1  D- line
// BEHAVIOUR
// - Reset (n_rst=0 at a clk edge): state IDLE, dplus_out=1, dminus_out=0 (J), all strobes 0, counters 0.
// - Reset mid-packet: lines return to J on that edge; partial packet abandoned; no pop.
// - Command acceptance
//   - Sampled only in IDLE. tx_packet 1-4 at edge N: tx_transfer_active=1 from N+1.
//   - First SYNC bit is driven from N+1.
//   - Nonzero tx_packet outside IDLE is ignored.
//   - tx_packet 5-7 in IDLE: tx_error=1 for one cycle; state stays IDLE; lines stay J.
// - Bit timer
//   - Counts 0..CLKS_PER_BIT-1; each line state is held exactly CLKS_PER_BIT cycles.
//   - Next bit loads at wrap.
// - Bit order: every field LSB first. Byte values:
//   - SYNC 0x80; PID DATA0 0xC3, ACK 0xD2, NAK 0x5A, STALL 0x1E.
// - States: IDLE -> SYNC -> PID -> (handshake: EOP1) | (DATA0: DATA or CRC1) ...
//   - DATA -> DATA | CRC1; CRC1 -> CRC2 -> EOP1 -> EOP2 -> EOPJ -> IDLE.
// - Payload fetch
//   - At the last bit time of PID/DATA, in the cycle before the timer wraps: if buffer_occupancy != 0,
//     pulse get_tx_packet_data and latch tx_packet_data into the shifter.
//   - Next state is DATA; else next state is CRC1. Exactly one pop per byte sent.
// - CRC16
//   - Polynomial x^16+x^15+x^2+1, init 0xFFFF, over payload bits only.
//   - Complement is sent, low byte (CRC1) then high byte (CRC2).
//   - Zero-length payload sends 0x00,0x00.
// - NRZI: data 0 toggles J<->K; data 1 holds the current line state. K = dplus 0 / dminus 1.
//   - Encoder starts from J at SYNC.
// - Bit stuffing
//   - Counts consecutive 1s from SYNC through CRC2.
//   - At the 6th, the next bit time carries a stuffed 0 (toggle); the shifter does not advance; count clears.
//   - A stuff bit owed after the final CRC/PID bit is sent before EOP1.
// - EOP: EOP1 and EOP2 drive SE0 (dplus 0, dminus 0); EOPJ drives J.
//   - tx_transfer_active falls on the edge leaving EOPJ.
// - Simultaneous events
//   - Reset overrides everything.
//   - A command seen in the same cycle IDLE is entered from EOPJ is not accepted; it must be held one more cycle.
// CONFIGURATION
// - USB_TX_BITSTUFF_EN
//   - Defined: bit stuffing as above (protocol-compliant).
//   - Undefined: stuffing logic is removed; the raw NRZI stream is sent with no inserted bits. Debug/loopback only.
// TESTING
// - Reset, idle 20 cycles -> dplus_out=1, dminus_out=0, all strobes 0 throughout.
// - ACK (tx_packet=2, one cycle) -> decoded bits 00000001 01001011, SE0, SE0, J.
//   - 19 bit times = 152 cycles; tx_transfer_active high exactly 152 cycles; no pop.
// - DATA0, occupancy 0 -> SYNC, 0xC3, CRC 0x00, 0x00, EOP; get_tx_packet_data never asserted.
// - DATA0, occupancy 1, byte 0xFF (stuffing on)
//   - Stuffed 0 appears after the 4th payload bit (PID ends in two 1s).
//   - One pop; CRC matches the bench golden model.
// - DATA0, 64 bytes 0x00..0x3F -> exactly 64 pops, bytes in order, CRC matches the golden model.
//   - tx_packet=2 pulsed mid-packet is ignored.
// - tx_packet=6 -> tx_error one cycle, lines J.
//   - Separately: n_rst=0 during payload -> lines J on the next edge, tx_transfer_active=0.

Source files
------------

// File: rtl/usb_tx.sv
// usb_tx - USB full-speed packet transmitter.
//
// Takes a packet command from the protocol controller, pulls payload bytes from the
// shared data buffer and serialises SYNC, PID, payload, CRC16 and EOP onto the bus.
// Every field goes out LSB first. The bus is NRZI encoded and, optionally, bit stuffed.
//
// Parameters
//   CLKS_PER_BIT        clk cycles per USB bit time (>= 2)
// Ports
//   clk                 system clock, rising edge
//   n_rst               synchronous active-low reset
//   tx_packet           command: 0 none, 1 DATA0, 2 ACK, 3 NAK, 4 STALL, 5-7 illegal
//   buffer_occupancy    bytes waiting in the data buffer
//   tx_packet_data      buffer head byte, valid while get_tx_packet_data is high
//   get_tx_packet_data  one-cycle pop strobe to the data buffer
//   tx_transfer_active  high while a packet is on the bus
//   tx_error            one-cycle pulse when an illegal command is rejected
//   dplus_out           D+ line
//   dminus_out          D- line
//
// Build option
//   USB_TX_BITSTUFF_EN  defined: protocol-compliant bit stuffing.
//                       undefined: raw NRZI stream with no stuffed bits (debug/loopback).

module usb_tx #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dplus_out,
    output logic       dminus_out
);

    localparam int unsigned   CntW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    localparam logic [7:0] SyncByte = 8'h80;
    localparam logic [7:0] PidData0 = 8'hC3;
    localparam logic [7:0] PidAck   = 8'hD2;
    localparam logic [7:0] PidNak   = 8'h5A;
    localparam logic [7:0] PidStall = 8'h1E;

    typedef enum logic [3:0] {
        StIdle,
        StSync,
        StPid,
        StData,
        StCrc1,
        StCrc2,
        StEop1,
        StEop2,
        StEopJ
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      field_q, field_d;     // byte currently being serialised
    logic [2:0]      bit_idx_q, bit_idx_d; // index of the field bit on the wire
    logic [15:0]     crc_q, crc_d;
    logic [7:0]      pid_q, pid_d;
    logic            lvl_q, lvl_d;         // NRZI line level, 1 = J
    logic            err_q, err_d;

    logic tick;        // last cycle of the current bit time
    logic stuff_owed;  // next bit time must carry a stuffed 0
    logic load_bit;    // a field bit is loaded onto the wire at this edge
    logic load_stuff;  // a stuffed 0 is loaded onto the wire at this edge
    logic next_bit;
    logic pop;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        field_d    = field_q;
        bit_idx_d  = bit_idx_q;
        crc_d      = crc_q;
        pid_d      = pid_q;
        lvl_d      = lvl_q;
        err_d      = 1'b0;
        load_bit   = 1'b0;
        load_stuff = 1'b0;
        next_bit   = 1'b0;
        pop        = 1'b0;

        if (state_q == StIdle) begin
            cnt_d = '0;
            if (tx_packet inside {[3'd1:3'd4]}) begin
                state_d   = StSync;
                field_d   = SyncByte;
                bit_idx_d = '0;
                crc_d     = 16'hFFFF;
                load_bit  = 1'b1;
                next_bit  = 1'b0;  // SYNC starts with a 0, so the line goes to K at once
                case (tx_packet)
                    3'd1:    pid_d = PidData0;
                    3'd2:    pid_d = PidAck;
                    3'd3:    pid_d = PidNak;
                    default: pid_d = PidStall;
                endcase
            end else if (tx_packet != 3'd0) begin
                err_d = 1'b1;
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
            if (tick) begin
                unique case (state_q)
                    StSync, StPid, StData, StCrc1, StCrc2: begin
                        if (stuff_owed) begin
                            // the field index holds, so the stuff bit slots in between
                            load_stuff = 1'b1;
                        end else if (bit_idx_q != 3'd7) begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            load_bit  = 1'b1;
                            next_bit  = field_q[bit_idx_q + 3'd1];
                        end else begin
                            bit_idx_d = '0;
                            load_bit  = 1'b1;
                            if (state_q == StSync) begin
                                state_d = StPid;
                                field_d = pid_q;
                            end else if (state_q == StCrc1) begin
                                state_d = StCrc2;
                                field_d = ~crc_q[15:8];
                            end else if (state_q == StCrc2 || pid_q != PidData0) begin
                                state_d  = StEop1;
                                load_bit = 1'b0;
                                lvl_d    = 1'b1;  // park the encoder at J for the next packet
                            end else if (buffer_occupancy != 7'd0) begin
                                state_d = StData;
                                field_d = tx_packet_data;
                                pop     = 1'b1;
                            end else begin
                                state_d = StCrc1;
                                field_d = ~crc_q[7:0];
                            end
                            next_bit = field_d[0];
                        end
                    end
                    StEop1:  state_d = StEop2;
                    StEop2:  state_d = StEopJ;
                    StEopJ:  state_d = StIdle;
                    default: state_d = StIdle;
                endcase
            end
        end

        // NRZI: a 0 toggles the line, a 1 holds it
        if ((load_bit && !next_bit) || load_stuff) begin
            lvl_d = ~lvl_q;
        end

        // reflected CRC16 (x^16+x^15+x^2+1), fed one payload bit at a time as it goes out
        if (load_bit && state_d == StData) begin
            if (next_bit ^ crc_q[0]) begin
                crc_d = {1'b0, crc_q[15:1]} ^ 16'hA001;
            end else begin
                crc_d = {1'b0, crc_q[15:1]};
            end
        end
    end

`ifdef USB_TX_BITSTUFF_EN
    logic [2:0] ones_q, ones_d;

    assign stuff_owed = (ones_q == 3'd6);

    always_comb begin
        ones_d = ones_q;
        if (load_stuff) begin
            ones_d = '0;
        end else if (load_bit) begin
            ones_d = next_bit ? ones_q + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end
`else
    assign stuff_owed = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            field_q   <= '0;
            bit_idx_q <= '0;
            crc_q     <= '0;
            pid_q     <= '0;
            lvl_q     <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            field_q   <= field_d;
            bit_idx_q <= bit_idx_d;
            crc_q     <= crc_d;
            pid_q     <= pid_d;
            lvl_q     <= lvl_d;
            err_q     <= err_d;
        end
    end

    // a reset edge abandons the packet, so it must not consume a buffer byte
    assign get_tx_packet_data = pop && n_rst;
    assign tx_transfer_active = (state_q != StIdle);
    assign tx_error           = err_q;

    always_comb begin
        dplus_out  = 1'b1;
        dminus_out = 1'b0;
        case (state_q)
            StSync, StPid, StData, StCrc1, StCrc2: begin
                dplus_out  = lvl_q;
                dminus_out = ~lvl_q;
            end
            StEop1, StEop2: begin
                dplus_out  = 1'b0;
                dminus_out = 1'b0;
            end
            default: begin
                dplus_out  = 1'b1;
                dminus_out = 1'b0;
            end
        endcase
    end

endmodule
